// File: rtl/mem_responder.sv
// Unified 256x16 program/data memory answering the processor bus: sweeps itself to zero
// after clr, takes a program image from the loader port, then releases cpu_rst.
// Optional MEM_WPROT_EN: RUN-phase bus writes below PROT_BASE are dropped and flagged.
//
// Loader handshake: a word is transferred on any rising edge where ld_valid && ld_ready.
// ld_ready is a registered state decode, high only in LOAD, and never waits on ld_valid.
// ld_done is sampled only in LOAD. A word presented with ld_done in the same cycle is still taken.
module mem_responder #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'h80
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] adrs,
  input  logic              rw,
  input  logic [7:0]        dout,
  output logic [DATA_W-1:0] din,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              cpu_rst,
  output logic              wp_err,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                we;
  logic [ADDR_W-1:0]   wa;
  logic [DATA_W-1:0]   wd;
  logic                wp_hit;

`ifdef MEM_WPROT_EN
  assign wp_hit = rw && (adrs < PROT_BASE);
`else
  assign wp_hit = 1'b0;
`endif

  // Single write port shared by the clear sweep, the loader and the processor bus.
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    wa      = ptr_q;
    wd      = '0;
    case (state_q)
      CLEAR: begin
        we = 1'b1;
        wa = ptr_q;
        if (&ptr_q) state_d = LOAD;
      end
      LOAD: begin
        if (ld_valid && ld_ready) begin
          we = 1'b1;
          wa = ld_addr;
          wd = ld_data;
        end
        if (ld_done) state_d = RUN;
      end
      RUN: begin
        if (rw && !wp_hit) begin
          we = 1'b1;
          wa = adrs;
          wd = {{(DATA_W-8){1'b0}}, dout};
        end
      end
      default: state_d = CLEAR;
    endcase
    if (clr) begin
      state_d = CLEAR;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      ld_ready <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      state_q  <= state_d;
      if (state_q == CLEAR && !(&ptr_q)) ptr_q <= ptr_q + 1'b1;
      ld_ready <= (state_d == LOAD);
      cpu_rst  <= (state_d != RUN);
    end
  end

`ifdef MEM_WPROT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      wp_err <= 1'b0;
    end else if (state_q == RUN && wp_hit) begin
      wp_err <= 1'b1;
    end
  end
`else
  assign wp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Zero-latency read: the decoder samples din on the edge after it drives adrs.
  assign din       = mem[adrs];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: clear sweep timing, image load, RUN bus writes,
// ignored loader traffic, reset restarts and (with MEM_WPROT_EN) write protection.
module tb_mem_responder;

  logic        clk;
  logic        clr;
  logic [7:0]  adrs;
  logic        rw;
  logic [7:0]  dout;
  logic [15:0] din;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_done;
  logic        cpu_rst;
  logic        wp_err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  mem_responder dut (
    .clk       (clk),
    .clr       (clr),
    .adrs      (adrs),
    .rw        (rw),
    .dout      (dout),
    .din       (din),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_done   (ld_done),
    .cpu_rst   (cpu_rst),
    .wp_err    (wp_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    check("clr_cpu_rst", cpu_rst, 1);
    check("clr_ld_ready", ld_ready, 0);
    check("clr_state", dbg_state, 0);
    clr = 1'b0;
  endtask

  // 256 CLEAR cycles with cpu_rst=1, ld_ready=0, then LOAD with ld_ready=1.
  // With inject set, bus writes and loader words are offered mid-sweep to already-cleared addresses.
  task automatic sweep_check(input bit inject);
    for (int i = 0; i < 256; i++) begin
      check("sweep_cpu_rst", cpu_rst, 1);
      check("sweep_ld_ready", ld_ready, 0);
      check("sweep_state", dbg_state, 0);
      if (inject && i == 10) begin
        rw = 1'b1; adrs = 8'h03; dout = 8'hAA;
        ld_valid = 1'b1; ld_addr = 8'h04; ld_data = 16'hBEEF;
      end
      if (inject && i == 20) begin
        rw = 1'b0; ld_valid = 1'b0;
      end
      tick();
    end
    check("load_ld_ready", ld_ready, 1);
    check("load_cpu_rst", cpu_rst, 1);
    check("load_state", dbg_state, 1);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d, input logic done);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_done = done;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    adrs = a; rw = 1'b1; dout = d;
    tick();
    rw = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    clr = 1'b1; adrs = '0; rw = 1'b0; dout = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    tick();
    tick();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_wp_err", wp_err, 0);
    check("rst_state", dbg_state, 0);
    clr = 1'b0;

    sweep_check(1'b1);
    for (int a = 0; a < 256; a += 17) begin
      adrs = 8'(a); #1;
      check("cleared_din", din, 16'h0000);
    end
    adrs = 8'h03; #1; check("clear_ignores_bus", din, 16'h0000);
    adrs = 8'h04; #1; check("clear_ignores_loader", din, 16'h0000);

    // Image load, repeated address, done together with the last word
    load_word(8'h00, 16'h1A05, 1'b0);
    load_word(8'h02, 16'h1111, 1'b0);
    rw = 1'b1; adrs = 8'h05; dout = 8'h99;
    load_word(8'h02, 16'h2222, 1'b0);
    rw = 1'b0;
    load_word(8'h90, 16'hABCD, 1'b0);
    check("load_still_cpu_rst", cpu_rst, 1);
    load_word(8'h01, 16'h2B06, 1'b1);
    check("run_cpu_rst", cpu_rst, 0);
    check("run_ld_ready", ld_ready, 0);
    check("run_state", dbg_state, 2);
    adrs = 8'h01; #1; check("load_w1", din, 16'h2B06);
    adrs = 8'h00; #1; check("load_w0", din, 16'h1A05);
    adrs = 8'h02; #1; check("load_last_wins", din, 16'h2222);
    adrs = 8'h05; #1; check("load_ignores_bus", din, 16'h0000);

    // RUN bus write: old word visible in the write cycle, new word after the edge
    adrs = 8'hF0; rw = 1'b1; dout = 8'h5C; #1;
    check("run_write_old", din, 16'h0000);
    tick();
    rw = 1'b0; #1;
    check("run_write_new", din, 16'h005C);
    bus_write(8'h90, 8'h12);
    adrs = 8'h90; #1; check("run_upper_cleared", din, 16'h0012);

    // Loader traffic in RUN is ignored
    ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'hFFFF; ld_done = 1'b1;
    tick();
    check("run_ld_ready_low", ld_ready, 0);
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
    adrs = 8'h00; #1; check("run_ld_ignored", din, 16'h1A05);
    check("run_cpu_rst_stays", cpu_rst, 0);

    // Write-protect boundary
    bus_write(8'h10, 8'h77);
    adrs = 8'h10; #1;
`ifdef MEM_WPROT_EN
    check("wp_dropped", din, 16'h0000);
    check("wp_err_set", wp_err, 1);
`else
    check("wp_off_written", din, 16'h0077);
    check("wp_off_err", wp_err, 0);
`endif
    bus_write(8'h80, 8'h33);
    adrs = 8'h80; #1; check("wp_base_written", din, 16'h0033);
    tick(); tick();
`ifdef MEM_WPROT_EN
    check("wp_err_sticky", wp_err, 1);
`else
    check("wp_off_err_hold", wp_err, 0);
`endif

    // clr from RUN, then again mid-sweep at pointer 8'h40
    pulse_clr();
    check("clr_wp_err", wp_err, 0);
    for (int i = 0; i < 8'h40; i++) begin
      check("partial_cpu_rst", cpu_rst, 1);
      tick();
    end
    pulse_clr();
    sweep_check(1'b0);
    adrs = 8'hF0; #1; check("reclear_f0", din, 16'h0000);
    adrs = 8'h00; #1; check("reclear_00", din, 16'h0000);
    adrs = 8'h90; #1; check("reclear_90", din, 16'h0000);
    adrs = 8'h80; #1; check("reclear_80", din, 16'h0000);

    // clr during LOAD restarts the full sweep
    load_word(8'h07, 16'h0707, 1'b0);
    tick();
    pulse_clr();
    sweep_check(1'b0);
    adrs = 8'h07; #1; check("reload_cleared", din, 16'h0000);
    load_word(8'h07, 16'h4321, 1'b1);
    check("final_cpu_rst", cpu_rst, 0);
    adrs = 8'h07; #1; check("final_word", din, 16'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
